hbm_edge_rqst_gen: RTL and testbench

HBM_EDGE_RQST_GEN -- requirements
Module: hbm_edge_rqst_gen

---
 rtl/hbm_edge_rqst_gen_pkg.sv | 31 +++
 rtl/hbm_edge_rqst_gen_if.sv | 46 ++++
 rtl/edge_rqst_vertex_fifo.sv | 59 +++++
 rtl/hbm_edge_rqst_gen.sv | 154 +++++++++++++++
 tb/tb_hbm_edge_rqst_gen.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hbm_edge_rqst_gen_pkg.sv
// Shared widths, FIFO sizing and types for the HBM edge-request generator.
// The vertex record is the unit stored in the vertex FIFO.
package hbm_edge_rqst_gen_pkg;

    localparam int V_ID_WIDTH     = 20;
    localparam int V_OFF_DWIDTH   = 32;
    localparam int HBM_AWIDTH     = 33;
    localparam int HBM_EDGE_MASK  = 8;
    localparam int LINE_BYTES_LOG = 5;

    localparam int EDGE_IDX_LOG   = $clog2(HBM_EDGE_MASK);
    localparam int LINE_IDX_W     = V_OFF_DWIDTH - EDGE_IDX_LOG;

    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_AFULL     = 12;
    localparam int FIFO_CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rqst_state_e;

    typedef struct packed {
        logic [V_ID_WIDTH-1:0]   v_id;
        logic [V_OFF_DWIDTH-1:0] loffset;
        logic [V_OFF_DWIDTH-1:0] roffset;
    } vertex_t;

    localparam int VERTEX_W = $bits(vertex_t);

endpackage

// File: rtl/hbm_edge_rqst_gen_if.sv
// Vertex input, downstream backpressure and HBM line-request bundle.
// master drives vertices and consumes requests; slave is the generator.
interface hbm_edge_rqst_gen_if;
    import hbm_edge_rqst_gen_pkg::*;

    logic [V_ID_WIDTH-1:0]    front_active_v_id;
    logic [V_OFF_DWIDTH-1:0]  front_active_v_loffset;
    logic [V_OFF_DWIDTH-1:0]  front_active_v_roffset;
    logic                     front_active_v_valid;
    logic                     stage_full;
    logic                     hbm_interface_full;
    logic [HBM_AWIDTH-1:0]    rd_hbm_edge_addr;
    logic                     rd_hbm_edge_valid;
    logic [V_ID_WIDTH-1:0]    rd_hbm_edge_v_id;
    logic [HBM_EDGE_MASK-1:0] rd_hbm_edge_mask;
    logic                     overflow_err;

    modport master (
        output front_active_v_id,
        output front_active_v_loffset,
        output front_active_v_roffset,
        output front_active_v_valid,
        output hbm_interface_full,
        input  stage_full,
        input  rd_hbm_edge_addr,
        input  rd_hbm_edge_valid,
        input  rd_hbm_edge_v_id,
        input  rd_hbm_edge_mask,
        input  overflow_err
    );

    modport slave (
        input  front_active_v_id,
        input  front_active_v_loffset,
        input  front_active_v_roffset,
        input  front_active_v_valid,
        input  hbm_interface_full,
        output stage_full,
        output rd_hbm_edge_addr,
        output rd_hbm_edge_valid,
        output rd_hbm_edge_v_id,
        output rd_hbm_edge_mask,
        output overflow_err
    );

endinterface

// File: rtl/edge_rqst_vertex_fifo.sv
// Synchronous show-ahead vertex FIFO with occupancy count.
// Head entry is visible on rd_data whenever empty is low; writes at full are dropped.
module edge_rqst_vertex_fifo
    import hbm_edge_rqst_gen_pkg::*;
#(
    parameter int DATA_W = VERTEX_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_wr;
    logic              do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign count = cnt;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/hbm_edge_rqst_gen.sv
// Splits each active vertex's edge range [loffset, roffset) into one HBM
// line request per covered line, with a per-edge ownership mask.
module hbm_edge_rqst_gen
    import hbm_edge_rqst_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    hbm_edge_rqst_gen_if.slave bus
);

    function automatic logic [LINE_IDX_W-1:0] line_of(input logic [V_OFF_DWIDTH-1:0] off);
        return off[V_OFF_DWIDTH-1:EDGE_IDX_LOG];
    endfunction

    function automatic logic [HBM_AWIDTH-1:0] line_addr(input logic [LINE_IDX_W-1:0] line);
        logic [HBM_AWIDTH-1:0] a;
        a = HBM_AWIDTH'(line);
        return a << LINE_BYTES_LOG;
    endfunction

    function automatic logic [HBM_EDGE_MASK-1:0] edge_mask(
        input logic                    is_first,
        input logic                    is_last,
        input logic [EDGE_IDX_LOG-1:0] lo,
        input logic [EDGE_IDX_LOG-1:0] hi
    );
        logic [HBM_EDGE_MASK-1:0] m;
        m = '1;
        if (is_first) m = m & ({HBM_EDGE_MASK{1'b1}} << lo);
        if (is_last)  m = m & ({HBM_EDGE_MASK{1'b1}} >> (EDGE_IDX_LOG'(HBM_EDGE_MASK - 1) - hi));
        return m;
    endfunction

    vertex_t                 wr_vtx;
    vertex_t                 rd_vtx;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_pop;
    logic [FIFO_CNT_W-1:0]   fifo_count;

    rqst_state_e             state_q;
    rqst_state_e             state_d;
    logic                    load;
    logic                    issue;
    logic [V_OFF_DWIDTH-1:0] rend;

    logic [LINE_IDX_W-1:0]   cur_line_p0;
    logic [LINE_IDX_W-1:0]   first_line_p0;
    logic [LINE_IDX_W-1:0]   last_line_p0;
    logic [EDGE_IDX_LOG-1:0] lo_bit_p0;
    logic [EDGE_IDX_LOG-1:0] hi_bit_p0;
    logic [V_ID_WIDTH-1:0]   v_id_p0;

    logic                    vld_p1;
    logic [HBM_AWIDTH-1:0]   addr_p1;
    logic [HBM_EDGE_MASK-1:0] mask_p1;
    logic [V_ID_WIDTH-1:0]   v_id_p1;
    logic                    overflow_q;

    assign wr_vtx.v_id    = bus.front_active_v_id;
    assign wr_vtx.loffset = bus.front_active_v_loffset;
    assign wr_vtx.roffset = bus.front_active_v_roffset;

    edge_rqst_vertex_fifo #(
        .DATA_W (VERTEX_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (FIFO_CNT_W)
    ) u_vertex_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.front_active_v_valid),
        .wr_data (wr_vtx),
        .rd_en   (fifo_pop),
        .rd_data (rd_vtx),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Upstream is told to stop early; the last four slots absorb in-flight strobes.
    assign bus.stage_full = (fifo_count >= FIFO_CNT_W'(FIFO_AFULL));

    assign rend = rd_vtx.roffset - V_OFF_DWIDTH'(1);

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load     = 1'b0;
        issue    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Empty ranges are consumed without producing a request.
                    if (rd_vtx.loffset < rd_vtx.roffset) begin
                        load    = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!bus.hbm_interface_full) begin
                    issue = 1'b1;
                    if (cur_line_p0 == last_line_p0) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // p0: line bounds of the vertex being issued
    always_ff @(posedge clk) begin
        if (load) begin
            first_line_p0 <= line_of(rd_vtx.loffset);
            cur_line_p0   <= line_of(rd_vtx.loffset);
            last_line_p0  <= line_of(rend);
            lo_bit_p0     <= rd_vtx.loffset[EDGE_IDX_LOG-1:0];
            hi_bit_p0     <= rend[EDGE_IDX_LOG-1:0];
            v_id_p0       <= rd_vtx.v_id;
        end else if (issue) begin
            cur_line_p0   <= cur_line_p0 + LINE_IDX_W'(1);
        end
    end

    // p1: registered request outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vld_p1     <= 1'b0;
            addr_p1    <= '0;
            mask_p1    <= '0;
            v_id_p1    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= issue;
            if (issue) begin
                addr_p1 <= line_addr(cur_line_p0);
                mask_p1 <= edge_mask(cur_line_p0 == first_line_p0,
                                     cur_line_p0 == last_line_p0,
                                     lo_bit_p0, hi_bit_p0);
                v_id_p1 <= v_id_p0;
            end
            if (bus.front_active_v_valid && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign bus.rd_hbm_edge_valid = vld_p1;
    assign bus.rd_hbm_edge_addr  = addr_p1;
    assign bus.rd_hbm_edge_mask  = mask_p1;
    assign bus.rd_hbm_edge_v_id  = v_id_p1;
    assign bus.overflow_err      = overflow_q;

endmodule

// File: tb/tb_hbm_edge_rqst_gen.sv
// Bench for hbm_edge_rqst_gen: directed scenarios plus randomized vertices
// checked against an edge-by-edge reference model of the line requests.
module tb_hbm_edge_rqst_gen;
    import hbm_edge_rqst_gen_pkg::*;

    typedef struct {
        logic [HBM_AWIDTH-1:0]    addr;
        logic [HBM_EDGE_MASK-1:0] mask;
        logic [V_ID_WIDTH-1:0]    vid;
        int                       cyc;
        logic                     full;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    logic full_at_edge = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    req_t obs_q[$];
    req_t exp_q[$];
    req_t mon_r;

    hbm_edge_rqst_gen_if bus();

    hbm_edge_rqst_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        full_at_edge <= bus.hbm_interface_full;
    end

    always @(negedge clk) begin
        if (bus.rd_hbm_edge_valid === 1'b1) begin
            mon_r.addr = bus.rd_hbm_edge_addr;
            mon_r.mask = bus.rd_hbm_edge_mask;
            mon_r.vid  = bus.rd_hbm_edge_v_id;
            mon_r.cyc  = cyc;
            mon_r.full = full_at_edge;
            obs_q.push_back(mon_r);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_v(input logic [V_ID_WIDTH-1:0] id, input int l, input int r);
        step();
        bus.front_active_v_id      = id;
        bus.front_active_v_loffset = 32'(l);
        bus.front_active_v_roffset = 32'(r);
        bus.front_active_v_valid   = 1'b1;
    endtask

    task automatic end_push();
        step();
        bus.front_active_v_valid = 1'b0;
    endtask

    // Reference: walk every edge of the range and group edges by HBM line.
    task automatic model_vertex(input logic [V_ID_WIDTH-1:0] id, input int l, input int r);
        req_t t;
        int   line;
        line   = -1;
        t.addr = '0; t.mask = '0; t.vid = '0; t.cyc = 0; t.full = 1'b0;
        for (int e = l; e < r; e++) begin
            if (e / 8 != line) begin
                if (line >= 0) exp_q.push_back(t);
                line   = e / 8;
                t.addr = 33'(line) * 33'd32;
                t.mask = 8'h00;
                t.vid  = id;
            end
            t.mask[3'(e % 8)] = 1'b1;
        end
        if (line >= 0) exp_q.push_back(t);
    endtask

    task automatic clear_queues();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.front_active_v_id      = '0;
        bus.front_active_v_loffset = '0;
        bus.front_active_v_roffset = '0;
        bus.front_active_v_valid   = 1'b0;
        bus.hbm_interface_full     = 1'b0;
        rst = 1'b0;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.rd_hbm_edge_valid, bus.rd_hbm_edge_addr, bus.rd_hbm_edge_mask, bus.rd_hbm_edge_v_id} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b addr=%h mask=%h vid=%h expected all zero",
                     bus.rd_hbm_edge_valid, bus.rd_hbm_edge_addr, bus.rd_hbm_edge_mask, bus.rd_hbm_edge_v_id);
        end
        n_checks++;
        if (bus.stage_full !== 1'b0 || bus.overflow_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got stage_full=%b overflow_err=%b expected 0 0", bus.stage_full, bus.overflow_err);
        end
        step(); step();
        rst = 1'b0;
        step(); step();
        n_checks++;
        if (bus.rd_hbm_edge_valid !== 1'b0 || bus.stage_full !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got valid=%b stage_full=%b expected 0 0", bus.rd_hbm_edge_valid, bus.stage_full);
        end
    endtask

    task automatic test_basic();
        int c;
        clear_queues();
        push_v(20'd5, 3, 20);
        c = cyc;
        end_push();
        model_vertex(20'd5, 3, 20);
        repeat (12) step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].mask !== exp_q[i].mask ||
                obs_q[i].vid !== exp_q[i].vid || obs_q[i].cyc !== obs_q[0].cyc + i) begin
                n_errors++;
                $display("FAIL basic_req%0d: got addr=%h mask=%h vid=%h cyc=%0d expected addr=%h mask=%h vid=%h cyc=%0d",
                         i, obs_q[i].addr, obs_q[i].mask, obs_q[i].vid, obs_q[i].cyc,
                         exp_q[i].addr, exp_q[i].mask, exp_q[i].vid, obs_q[0].cyc + i);
            end
        end
        if (obs_q.size() == 3) begin
            n_checks++;
            if (obs_q[0].mask !== 8'hF8 || obs_q[1].mask !== 8'hFF || obs_q[2].mask !== 8'h0F ||
                obs_q[2].addr !== 33'h40) begin
                n_errors++;
                $display("FAIL basic_literal: got masks %h %h %h last addr %h expected F8 FF 0F 40",
                         obs_q[0].mask, obs_q[1].mask, obs_q[2].mask, obs_q[2].addr);
            end
            n_checks++;
            if (obs_q[0].cyc !== c + 3) begin
                n_errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", obs_q[0].cyc, c + 3);
            end
        end
    endtask

    task automatic test_discard();
        clear_queues();
        push_v(20'd1, 40, 40);
        push_v(20'd7, 9, 10);
        end_push();
        model_vertex(20'd1, 40, 40);
        model_vertex(20'd7, 9, 10);
        repeat (10) step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL discard_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        if (obs_q.size() >= 1) begin
            n_checks++;
            if (obs_q[0].addr !== 33'h20 || obs_q[0].mask !== 8'h02 || obs_q[0].vid !== 20'd7) begin
                n_errors++;
                $display("FAIL discard_req: got addr=%h mask=%h vid=%h expected addr=20 mask=02 vid=7",
                         obs_q[0].addr, obs_q[0].mask, obs_q[0].vid);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        push_v(20'd10, 0, 8);
        push_v(20'd11, 8, 16);
        end_push();
        model_vertex(20'd10, 0, 8);
        model_vertex(20'd11, 8, 16);
        repeat (12) step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].mask !== exp_q[i].mask || obs_q[i].vid !== exp_q[i].vid) begin
                n_errors++;
                $display("FAIL b2b_req%0d: got addr=%h mask=%h vid=%h expected addr=%h mask=%h vid=%h",
                         i, obs_q[i].addr, obs_q[i].mask, obs_q[i].vid, exp_q[i].addr, exp_q[i].mask, exp_q[i].vid);
            end
        end
        if (obs_q.size() == 2) begin
            n_checks++;
            if (obs_q[1].cyc - obs_q[0].cyc !== 2) begin
                n_errors++; $display("FAIL b2b_gap: got %0d cycles expected 2", obs_q[1].cyc - obs_q[0].cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_queues();
        push_v(20'd2, 0, 64);
        end_push();
        model_vertex(20'd2, 0, 64);
        step(); step();
        bus.hbm_interface_full = 1'b1;
        step(); step(); step();
        bus.hbm_interface_full = 1'b0;
        repeat (14) step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].mask !== exp_q[i].mask ||
                obs_q[i].vid !== exp_q[i].vid || obs_q[i].full !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_req%0d: got addr=%h mask=%h vid=%h during_full=%b expected addr=%h mask=%h vid=%h during_full=0",
                         i, obs_q[i].addr, obs_q[i].mask, obs_q[i].vid, obs_q[i].full,
                         exp_q[i].addr, exp_q[i].mask, exp_q[i].vid);
            end
        end
        if (obs_q.size() == 8) begin
            n_checks++;
            if (obs_q[7].cyc - obs_q[0].cyc !== 10) begin
                n_errors++; $display("FAIL bp_span: got %0d cycles expected 10", obs_q[7].cyc - obs_q[0].cyc);
            end
        end
    endtask

    task automatic test_overflow();
        clear_queues();
        bus.hbm_interface_full = 1'b1;
        push_v(20'd100, 0, 8);
        end_push();
        model_vertex(20'd100, 0, 8);
        repeat (3) step();
        for (int k = 1; k <= 17; k++) begin
            step();
            bus.front_active_v_id      = 20'(k);
            bus.front_active_v_loffset = 32'(8 * k);
            bus.front_active_v_roffset = 32'(8 * k + 8);
            bus.front_active_v_valid   = 1'b1;
            if (k <= 16) model_vertex(20'(k), 8 * k, 8 * k + 8);
            if (k > 1) begin
                n_checks++;
                if (bus.stage_full !== ((k - 1) >= 12) || bus.overflow_err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL ovf_write%0d: got stage_full=%b overflow_err=%b expected %b 0",
                             k - 1, bus.stage_full, bus.overflow_err, (k - 1) >= 12);
                end
            end
        end
        step();
        bus.front_active_v_valid = 1'b0;
        n_checks++;
        if (bus.stage_full !== 1'b1 || bus.overflow_err !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_drop: got stage_full=%b overflow_err=%b expected 1 1", bus.stage_full, bus.overflow_err);
        end
        bus.hbm_interface_full = 1'b0;
        repeat (80) step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].mask !== exp_q[i].mask ||
                obs_q[i].vid !== exp_q[i].vid || obs_q[i].full !== 1'b0) begin
                n_errors++;
                $display("FAIL ovf_req%0d: got addr=%h mask=%h vid=%h expected addr=%h mask=%h vid=%h",
                         i, obs_q[i].addr, obs_q[i].mask, obs_q[i].vid, exp_q[i].addr, exp_q[i].mask, exp_q[i].vid);
            end
        end
        n_checks++;
        if (bus.stage_full !== 1'b0 || bus.overflow_err !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_after_drain: got stage_full=%b overflow_err=%b expected 0 1", bus.stage_full, bus.overflow_err);
        end
    endtask

    task automatic test_mid_reset();
        int i;
        clear_queues();
        push_v(20'd3, 0, 40);
        end_push();
        i = 0;
        while (obs_q.size() < 2 && i < 20) begin
            step();
            i++;
        end
        n_checks++;
        if (obs_q.size() !== 2) begin
            n_errors++; $display("FAIL midrst_wait: got %0d requests expected 2 within budget", obs_q.size());
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.rd_hbm_edge_valid, bus.rd_hbm_edge_addr, bus.rd_hbm_edge_mask, bus.rd_hbm_edge_v_id,
             bus.overflow_err, bus.stage_full} !== '0) begin
            n_errors++;
            $display("FAIL midrst_outputs: got valid=%b addr=%h mask=%h vid=%h ovf=%b stage_full=%b expected all zero",
                     bus.rd_hbm_edge_valid, bus.rd_hbm_edge_addr, bus.rd_hbm_edge_mask, bus.rd_hbm_edge_v_id,
                     bus.overflow_err, bus.stage_full);
        end
        step(); step();
        rst = 1'b0;
        repeat (15) step();
        n_checks++;
        if (obs_q.size() !== 2) begin
            n_errors++; $display("FAIL midrst_abandon: got %0d requests expected 2", obs_q.size());
        end
    endtask

    task automatic test_random();
        int pushed;
        int l;
        int len;
        logic [V_ID_WIDTH-1:0] id;
        clear_queues();
        pushed = 0;
        while (pushed < 40) begin
            step();
            bus.hbm_interface_full = ($urandom_range(0, 3) == 0);
            if (!bus.stage_full && $urandom_range(0, 1) == 1) begin
                id  = 20'($urandom);
                l   = int'($urandom_range(0, 500));
                len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
                bus.front_active_v_id      = id;
                bus.front_active_v_loffset = 32'(l);
                bus.front_active_v_roffset = 32'(l + len);
                bus.front_active_v_valid   = 1'b1;
                model_vertex(id, l, l + len);
                pushed++;
            end else begin
                bus.front_active_v_valid = 1'b0;
            end
        end
        step();
        bus.front_active_v_valid = 1'b0;
        bus.hbm_interface_full   = 1'b0;
        repeat (400) step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].mask !== exp_q[i].mask ||
                obs_q[i].vid !== exp_q[i].vid || obs_q[i].full !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_req%0d: got addr=%h mask=%h vid=%h during_full=%b expected addr=%h mask=%h vid=%h during_full=0",
                         i, obs_q[i].addr, obs_q[i].mask, obs_q[i].vid, obs_q[i].full,
                         exp_q[i].addr, exp_q[i].mask, exp_q[i].vid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_discard();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
